noc_ejector: RTL and testbench

- Receiving end of the mesh edge-port flit protocol. Sits on an "up" port of a mesh border node.
- Accepts HEADER/BODY/TAIL flits via the enable/ack handshake and checks the destination address against its own coordinate.
- Strips the header and delivers payload words, with a last marker, to a local consumer through a small FIFO using valid/ready.
- Counts delivered packets and flags address and protocol errors.

---
 rtl/noc_ejector_if.sv | 48 ++++
 rtl/noc_ejector.sv | 193 +++++++++++++++++++
 tb/tb_noc_ejector.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_ejector_if.sv
// Flit-side and consumer-side handshake bundle for the mesh ejector, plus the
// shared flit/header types.
package noc_ejector_pkg;
   localparam int FLIT_DATA_W = 16;

   typedef enum logic [1:0] {
      FLIT_HEADER = 2'd0,
      FLIT_BODY   = 2'd1,
      FLIT_TAIL   = 2'd2,
      FLIT_RSVD   = 2'd3
   } flit_type_e;

   typedef struct packed {
      flit_type_e                 flit_type;
      logic [FLIT_DATA_W-1:0]     data;
   } flit_t;

   // Header payload layout: destination x, destination y, number of BODY flits.
   typedef struct packed {
      logic [3:0] x;
      logic [3:0] y;
      logic [7:0] tail_length;
   } header_t;
endpackage

interface noc_ejector_if #(
   parameter int DATA_W = 16
);
   import noc_ejector_pkg::*;

   flit_t               in_flit;
   logic                in_enable;
   logic                in_ack;
   logic [DATA_W-1:0]   out_data;
   logic                out_last;
   logic                out_valid;
   logic                out_ready;

   modport master (
      output in_flit, in_enable, out_ready,
      input  in_ack, out_data, out_last, out_valid
   );

   modport slave (
      input  in_flit, in_enable, out_ready,
      output in_ack, out_data, out_last, out_valid
   );
endinterface

// File: rtl/noc_ejector.sv
// Mesh edge-port ejector: validates packet framing and destination, strips the
// header and queues payload words (with a last marker) for a local consumer.
module noc_ejector
   import noc_ejector_pkg::*;
#(
   parameter int MY_X       = 0,
   parameter int MY_Y       = 0,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   noc_ejector_if.slave      eif,
   output logic [CNT_W-1:0]  pkt_count,
   output logic              err_addr,
   output logic              err_proto
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [3:0] MY_X4 = MY_X[3:0];
   localparam logic [3:0] MY_Y4 = MY_Y[3:0];

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DROP = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   remaining_q, remaining_d;
   logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
   logic               err_addr_q, err_addr_d;
   logic               err_proto_q, err_proto_d;

   logic [DATA_W-1:0]  mem_data_q [FIFO_DEPTH];
   logic               mem_last_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;

   header_t            hdr;
   logic               is_header;
   logic               is_body;
   logic               is_tail;
   logic               hdr_is_mine;
   logic [CNT_W-1:0]   tail_len_ext;
   logic               fifo_full;
   logic               fifo_empty;
   logic               in_ack;
   logic               xfer;
   logic               push;
   logic               push_last;
   logic               pop;

   assign hdr          = header_t'(eif.in_flit.data);
   assign is_header    = (eif.in_flit.flit_type == FLIT_HEADER);
   assign is_body      = (eif.in_flit.flit_type == FLIT_BODY);
   assign is_tail      = (eif.in_flit.flit_type == FLIT_TAIL);
   assign hdr_is_mine  = (hdr.x == MY_X4) && (hdr.y == MY_Y4);
   assign tail_len_ext = CNT_W'(hdr.tail_length);

   assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);

   // A header in RECV is never pushed, so it must not be stalled by a full FIFO.
   always_comb begin
      in_ack = 1'b0;
      if (rst) begin
         if (state_q == ST_RECV) begin
            in_ack = !fifo_full || is_header;
         end else begin
            in_ack = 1'b1;
         end
      end
   end

   assign xfer = eif.in_enable && in_ack;
   assign pop  = !fifo_empty && eif.out_ready;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      pkt_count_d = pkt_count_q;
      err_addr_d  = err_addr_q;
      err_proto_d = err_proto_q;
      push        = 1'b0;
      push_last   = 1'b0;
      if (xfer) begin
         if (is_header) begin
            // A header arriving mid-packet aborts it; the new header is judged afresh.
            if (state_q == ST_RECV) begin
               err_proto_d = 1'b1;
            end
            if (hdr_is_mine) begin
               state_d     = ST_RECV;
               remaining_d = tail_len_ext;
            end else begin
               err_addr_d = 1'b1;
               state_d    = ST_DROP;
            end
         end else begin
            case (state_q)
               ST_IDLE: begin
                  err_proto_d = 1'b1;
               end
               ST_RECV: begin
                  if (is_body && remaining_q != '0) begin
                     push        = 1'b1;
                     remaining_d = remaining_q - CNT_W'(1);
                  end else if (is_tail) begin
                     if (remaining_q != '0) begin
                        err_proto_d = 1'b1;
                     end
                     push        = 1'b1;
                     push_last   = 1'b1;
                     pkt_count_d = pkt_count_q + CNT_W'(1);
                     state_d     = ST_IDLE;
                  end else begin
                     err_proto_d = 1'b1;
                     state_d     = ST_DROP;
                  end
               end
               ST_DROP: begin
                  if (is_tail) begin
                     state_d = ST_IDLE;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         pkt_count_q <= '0;
         err_addr_q  <= 1'b0;
         err_proto_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_q[i] <= '0;
            mem_last_q[i] <= 1'b0;
         end
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         pkt_count_q <= pkt_count_d;
         err_addr_q  <= err_addr_d;
         err_proto_q <= err_proto_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         if (push) begin
            mem_data_q[wr_ptr_q] <= DATA_W'(eif.in_flit.data);
            mem_last_q[wr_ptr_q] <= push_last;
         end
      end
   end

   assign eif.in_ack    = in_ack;
   assign eif.out_data  = mem_data_q[rd_ptr_q];
   assign eif.out_last  = mem_last_q[rd_ptr_q];
   assign eif.out_valid = !fifo_empty;

   assign pkt_count = pkt_count_q;
   assign err_addr  = err_addr_q;
   assign err_proto = err_proto_q;

endmodule

// File: tb/tb_noc_ejector.sv
// Bench for noc_ejector: directed scenarios plus randomized packets, checked
// every cycle against a packet-level reference model.
module tb_noc_ejector;
   import noc_ejector_pkg::*;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [15:0] pkt_count;
   logic        err_addr;
   logic        err_proto;

   noc_ejector_if #(.DATA_W(16)) eif ();

   noc_ejector #(
      .MY_X(1), .MY_Y(2), .DATA_W(16), .FIFO_DEPTH(DEPTH), .CNT_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .eif(eif),
      .pkt_count(pkt_count),
      .err_addr(err_addr),
      .err_proto(err_proto)
   );

   int checks = 0;
   int errors = 0;
   bit rand_ready = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired act=running req=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Reference model: packet-level view of what must have been delivered so far.
   typedef enum int {M_IDLE, M_RECV, M_DROP} mmode_e;
   mmode_e      m_mode = M_IDLE;
   int          m_left = 0;
   logic [15:0] m_pkt = '0;
   bit          m_ea = 0;
   bit          m_ep = 0;
   logic [16:0] mq[$];
   bit          is_hdr;
   bit          exp_ack;

   task automatic model_flit(input flit_t f);
      case (f.flit_type)
         FLIT_HEADER: begin
            if (m_mode == M_RECV) m_ep = 1;
            if (f.data[15:12] == 4'd1 && f.data[11:8] == 4'd2) begin
               m_mode = M_RECV;
               m_left = int'(f.data[7:0]);
            end else begin
               m_ea = 1;
               m_mode = M_DROP;
            end
         end
         FLIT_BODY: begin
            if (m_mode == M_IDLE) m_ep = 1;
            else if (m_mode == M_RECV) begin
               if (m_left > 0) begin
                  mq.push_back({1'b0, f.data});
                  m_left--;
               end else begin
                  m_ep = 1;
                  m_mode = M_DROP;
               end
            end
         end
         FLIT_TAIL: begin
            if (m_mode == M_IDLE) m_ep = 1;
            else if (m_mode == M_RECV) begin
               if (m_left > 0) m_ep = 1;
               mq.push_back({1'b1, f.data});
               m_pkt = m_pkt + 16'd1;
               m_mode = M_IDLE;
            end else begin
               m_mode = M_IDLE;
            end
         end
         default: ;
      endcase
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mq.delete();
         m_mode = M_IDLE;
         m_left = 0;
         m_pkt  = '0;
         m_ea   = 0;
         m_ep   = 0;
         chk("rst_in_ack", 32'(eif.in_ack), 0);
         chk("rst_out_valid", 32'(eif.out_valid), 0);
         chk("rst_out_data", 32'(eif.out_data), 0);
         chk("rst_pkt_count", 32'(pkt_count), 0);
         chk("rst_err_addr", 32'(err_addr), 0);
         chk("rst_err_proto", 32'(err_proto), 0);
      end else begin
         is_hdr  = (eif.in_flit.flit_type == FLIT_HEADER);
         exp_ack = (m_mode != M_RECV) || is_hdr || (mq.size() < DEPTH);
         chk("in_ack", 32'(eif.in_ack), 32'(exp_ack));
         chk("out_valid", 32'(eif.out_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            chk("out_data", 32'(eif.out_data), 32'(mq[0][15:0]));
            chk("out_last", 32'(eif.out_last), 32'(mq[0][16]));
         end
         chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
         chk("err_addr", 32'(err_addr), 32'(m_ea));
         chk("err_proto", 32'(err_proto), 32'(m_ep));
         if (mq.size() != 0 && eif.out_ready) void'(mq.pop_front());
         if (eif.in_enable && exp_ack) model_flit(eif.in_flit);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) eif.out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input flit_type_e t, input logic [15:0] d);
      int guard;
      guard = 0;
      eif.in_flit.flit_type = t;
      eif.in_flit.data      = d;
      eif.in_enable         = 1'b1;
      @(negedge clk);
      while (eif.in_ack !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("ack_wait_bound", 32'(guard < 200), 1);
      step();
      eif.in_enable = 1'b0;
   endtask

   function automatic logic [15:0] hdr_word(input int x, input int y, input int tl);
      return {x[3:0], y[3:0], tl[7:0]};
   endfunction

   task automatic send_pkt(input int x, input int y, input int tl, input int nb,
                           input logic [15:0] base, input int max_gap);
      send(FLIT_HEADER, hdr_word(x, y, tl));
      for (int i = 0; i < nb; i++) begin
         repeat ($urandom_range(0, max_gap)) step();
         send(FLIT_BODY, base + 16'(i));
      end
      repeat ($urandom_range(0, max_gap)) step();
      send(FLIT_TAIL, base + 16'(nb));
      $display("pkt dst=(%0d,%0d) tail_length=%0d bodies=%0d base=%h", x, y, tl, nb, base);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      rand_ready = 0;
      eif.out_ready = 1'b1;
      @(negedge clk);
      while (eif.out_valid && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_bound", 32'(guard < 200), 1);
      step();
   endtask

   initial begin
      rst = 1'b0;
      eif.in_enable = 1'b0;
      eif.in_flit   = '0;
      eif.out_ready = 1'b1;
      repeat (3) step();
      rst = 1'b1;
      step();

      // 1-word packet
      send(FLIT_HEADER, hdr_word(1, 2, 0));
      send(FLIT_TAIL, 16'hABCD);
      $display("pkt dst=(1,2) tail_length=0 single word");
      @(negedge clk);
      chk("basic_valid", 32'(eif.out_valid), 1);
      chk("basic_data", 32'(eif.out_data), 32'hABCD);
      chk("basic_last", 32'(eif.out_last), 1);
      chk("basic_pkt_count", 32'(pkt_count), 1);
      chk("basic_errs", 32'({err_addr, err_proto}), 0);
      step();

      // backpressure: FIFO fills after 4 pushes
      eif.out_ready = 1'b0;
      fork
         send_pkt(1, 2, 5, 5, 16'd1, 0);
         begin
            repeat (10) @(negedge clk);
            chk("full_blocks_ack", 32'(eif.in_ack), 0);
            chk("full_head_data", 32'(eif.out_data), 1);
            step();
            eif.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_pkt_count", 32'(pkt_count), 2);

      // foreign address dropped, then normal packet
      send_pkt(3, 3, 2, 2, 16'h0200, 0);
      @(negedge clk);
      chk("foreign_err_addr", 32'(err_addr), 1);
      chk("foreign_no_data", 32'(eif.out_valid), 0);
      chk("foreign_pkt_count", 32'(pkt_count), 2);
      step();
      send_pkt(1, 2, 1, 1, 16'h0300, 1);
      drain();
      chk("after_foreign_pkt_count", 32'(pkt_count), 3);

      // stray TAIL, then truncated packet
      send(FLIT_TAIL, 16'h5555);
      @(negedge clk);
      chk("stray_tail_err", 32'(err_proto), 1);
      chk("stray_tail_no_push", 32'(eif.out_valid), 0);
      step();
      send(FLIT_HEADER, hdr_word(1, 2, 2));
      send(FLIT_TAIL, 16'h4444);
      $display("pkt dst=(1,2) tail_length=2 truncated");
      @(negedge clk);
      chk("trunc_data", 32'(eif.out_data), 32'h4444);
      chk("trunc_last", 32'(eif.out_last), 1);
      chk("trunc_pkt_count", 32'(pkt_count), 4);
      step();
      drain();

      // reset mid-packet
      eif.out_ready = 1'b0;
      send(FLIT_HEADER, hdr_word(1, 2, 3));
      send(FLIT_BODY, 16'h0401);
      send(FLIT_BODY, 16'h0402);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 32'(eif.out_valid), 0);
      chk("midrst_ack", 32'(eif.in_ack), 0);
      step();
      rst = 1'b1;
      step();
      send(FLIT_BODY, 16'h0403);
      @(negedge clk);
      chk("post_rst_body_err", 32'(err_proto), 1);
      step();
      eif.out_ready = 1'b1;
      send_pkt(1, 2, 2, 2, 16'h0500, 0);
      drain();
      chk("post_rst_pkt_count", 32'(pkt_count), 1);

      // streaming with 2 entries resident and continuous pop
      eif.out_ready = 1'b0;
      send(FLIT_HEADER, hdr_word(1, 2, 9));
      send(FLIT_BODY, 16'h0600);
      send(FLIT_BODY, 16'h0601);
      eif.out_ready = 1'b1;
      for (int i = 2; i < 9; i++) send(FLIT_BODY, 16'h0600 + 16'(i));
      send(FLIT_TAIL, 16'h0609);
      $display("pkt dst=(1,2) tail_length=9 streamed");
      drain();
      chk("stream_pkt_count", 32'(pkt_count), 2);

      // randomized traffic
      rand_ready = 1;
      for (int p = 0; p < 40; p++) begin
         int kind;
         int tl;
         int nb;
         int x;
         int y;
         kind = $urandom_range(0, 9);
         tl   = $urandom_range(0, 6);
         x    = 1;
         y    = 2;
         if (kind == 0) begin
            send(($urandom_range(0, 1) != 0) ? FLIT_TAIL : FLIT_BODY, 16'($urandom));
            $display("stray flit");
         end else begin
            if (kind == 1) begin
               x = $urandom_range(0, 15);
               y = $urandom_range(0, 15);
            end
            nb = (kind == 2) ? $urandom_range(0, 8) : tl;
            send_pkt(x, y, tl, nb, 16'($urandom), 2);
         end
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
